// File: rtl/axis_arb_mux.sv
// Per-packet round-robin merge of S_COUNT AXI-Stream sources onto one registered sink; one idle arbitration cycle per packet.
// Output beat registered (accepted at edge N, valid from edge N); granted tready = !m_axis_tvalid || m_axis_tready, others held 0.
module axis_arb_mux #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int CL_S_COUNT = $clog2(S_COUNT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [S_COUNT-1:0]             s_axis_tvalid,
  output logic [S_COUNT-1:0]             s_axis_tready,
  input  logic [S_COUNT-1:0]             s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]    s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0]  s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0]  s_axis_tuser,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [ID_WIDTH-1:0]            m_axis_tid,
  output logic [DEST_WIDTH-1:0]          m_axis_tdest,
  output logic [USER_WIDTH-1:0]          m_axis_tuser,
  output logic                           grant_valid,
  output logic [CL_S_COUNT-1:0]          grant_index
);

  typedef enum logic {IDLE, GRANTED} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  state_t                state;
  logic [CL_S_COUNT-1:0] last_grant;
  logic [CL_S_COUNT-1:0] choice;
  logic                  req_any;
  logic                  sel_ready;
  logic                  in_xfer;
  logic                  out_vld;
  beat_t                 in_beat;
  beat_t                 out_beat;

  // Scan starts just after the previous grantee, so it becomes lowest priority.
  always_comb begin
    int idx;
    idx     = 0;
    choice  = '0;
    req_any = 1'b0;
    for (int k = 1; k <= S_COUNT; k++) begin
      idx = (int'(last_grant) + k) % S_COUNT;
      if (!req_any && s_axis_tvalid[idx]) begin
        req_any = 1'b1;
        choice  = CL_S_COUNT'(idx);
      end
    end
  end

  always_comb begin
    int g;
    g            = int'(grant_index);
    in_beat.data = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    in_beat.keep = s_axis_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH];
    in_beat.last = s_axis_tlast[g];
    in_beat.id   = s_axis_tid[g*ID_WIDTH +: ID_WIDTH];
    in_beat.dest = s_axis_tdest[g*DEST_WIDTH +: DEST_WIDTH];
    in_beat.user = s_axis_tuser[g*USER_WIDTH +: USER_WIDTH];
  end

  assign sel_ready = (state == GRANTED) && (!out_vld || m_axis_tready);
  assign in_xfer   = sel_ready && s_axis_tvalid[grant_index];

  always_comb begin
    s_axis_tready              = '0;
    s_axis_tready[grant_index] = sel_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_index <= '0;
      last_grant  <= CL_S_COUNT'(S_COUNT - 1);
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            state       <= GRANTED;
            grant_valid <= 1'b1;
            grant_index <= choice;
            last_grant  <= choice;
          end
        end
        GRANTED: begin
          if (in_xfer && in_beat.last) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

  // A fresh capture wins over a drain in the same cycle, giving one beat per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_vld  <= 1'b0;
      out_beat <= '0;
    end else if (in_xfer) begin
      out_vld  <= 1'b1;
      out_beat <= in_beat;
    end else if (m_axis_tready) begin
      out_vld  <= 1'b0;
    end
  end

  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_beat.data;
  assign m_axis_tkeep  = out_beat.keep;
  assign m_axis_tlast  = out_beat.last;
  assign m_axis_tid    = out_beat.id;
  assign m_axis_tdest  = out_beat.dest;
  assign m_axis_tuser  = out_beat.user;

endmodule

// File: tb/tb_axis_arb_mux.sv
// Bench for axis_arb_mux: directed scenarios plus randomized traffic, checked each cycle against a
// packet-level round-robin model and an end-to-end per-source scoreboard.
module tb_axis_arb_mux;
  localparam int S   = 4;
  localparam int DW  = 8;
  localparam int KW  = 1;
  localparam int IW  = 8;
  localparam int DSW = 8;
  localparam int UW  = 1;
  localparam int CL  = 2;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [KW-1:0]  keep;
    logic           last;
    logic [IW-1:0]  id;
    logic [DSW-1:0] dest;
    logic [UW-1:0]  user;
  } beat_t;

  logic            clk;
  logic            rst;
  logic [S*DW-1:0]  s_axis_tdata;
  logic [S*KW-1:0]  s_axis_tkeep;
  logic [S-1:0]     s_axis_tvalid;
  logic [S-1:0]     s_axis_tready;
  logic [S-1:0]     s_axis_tlast;
  logic [S*IW-1:0]  s_axis_tid;
  logic [S*DSW-1:0] s_axis_tdest;
  logic [S*UW-1:0]  s_axis_tuser;
  logic [DW-1:0]    m_axis_tdata;
  logic [KW-1:0]    m_axis_tkeep;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic [IW-1:0]    m_axis_tid;
  logic [DSW-1:0]   m_axis_tdest;
  logic [UW-1:0]    m_axis_tuser;
  logic             grant_valid;
  logic [CL-1:0]    grant_index;

  axis_arb_mux #(
    .S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW),
    .DEST_WIDTH(DSW), .USER_WIDTH(UW), .CL_S_COUNT(CL)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
    .grant_valid(grant_valid), .grant_index(grant_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus state: pending beats per source, beats accepted but not yet seen at the output.
  beat_t src_q[S][$];
  beat_t sb_q[S][$];
  bit    drv_vld[S];
  bit    rnd_mode = 1'b0;
  bit    rnd_sink = 1'b0;
  bit    sink_rdy = 1'b1;
  beat_t out_log[$];
  int    pkt_order[$];
  int    cur_out_src = -1;

  beat_t dut_b;
  assign dut_b = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser};

  function automatic beat_t src_beat(int i);
    beat_t b;
    b.data = s_axis_tdata[i*DW +: DW];
    b.keep = s_axis_tkeep[i*KW +: KW];
    b.last = s_axis_tlast[i];
    b.id   = s_axis_tid[i*IW +: IW];
    b.dest = s_axis_tdest[i*DSW +: DSW];
    b.user = s_axis_tuser[i*UW +: UW];
    return b;
  endfunction

  // Reference: packet-granular round robin with a single-slot output holding buffer.
  bit    m_gv;
  int    m_gi;
  int    m_last;
  bit    m_ovld;
  beat_t m_out;

  always @(posedge clk or negedge rst) begin : model
    bit    xfer;
    beat_t b;
    int    idx;
    if (!rst) begin
      m_gv = 0; m_gi = 0; m_last = S - 1; m_ovld = 0; m_out = '0;
    end else begin
      b    = src_beat(m_gi);
      xfer = m_gv && s_axis_tvalid[m_gi] && (!m_ovld || m_axis_tready);
      if (xfer) begin
        m_out  = b;
        m_ovld = 1;
      end else if (m_ovld && m_axis_tready) begin
        m_ovld = 0;
      end
      if (m_gv) begin
        if (xfer && b.last) m_gv = 0;
      end else begin
        for (int k = 1; k <= S; k++) begin
          idx = (m_last + k) % S;
          if (!m_gv && s_axis_tvalid[idx]) begin
            m_gv = 1; m_gi = idx; m_last = idx;
          end
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [S-1:0] er;
    beat_t        e;
    int           id;
    if (rst) begin
      er = '0;
      if (m_gv && (!m_ovld || m_axis_tready)) er[m_gi] = 1'b1;
      chk("s_tready", 64'(s_axis_tready), 64'(er));
      chk("m_tvalid", 64'(m_axis_tvalid), 64'(m_ovld));
      chk("grant_valid", 64'(grant_valid), 64'(m_gv));
      chk("grant_index", 64'(grant_index), 64'(m_gi));
      if (m_ovld) chk("m_beat", 64'(dut_b), 64'(m_out));
      if (m_axis_tvalid && m_axis_tready) begin
        out_log.push_back(dut_b);
        id = int'(dut_b.id);
        if (id < S && sb_q[id].size() > 0) begin
          e = sb_q[id].pop_front();
          chk("sb_beat", 64'(dut_b), 64'(e));
        end else begin
          total++; bad++;
          $display("FAIL sb_unexpected: output beat id %0d had no pending input beat", id);
        end
        if (cur_out_src >= 0) chk("contiguous_src", 64'(id), 64'(cur_out_src));
        cur_out_src = dut_b.last ? -1 : id;
        if (dut_b.last) pkt_order.push_back(id);
      end
    end
  end

  task automatic drive();
    beat_t       b;
    logic [31:0] r;
    for (int i = 0; i < S; i++) begin
      if (!drv_vld[i] && src_q[i].size() > 0 && (!rnd_mode || $urandom_range(9) < 7))
        drv_vld[i] = 1'b1;
      if (drv_vld[i]) begin
        b = src_q[i][0];
      end else begin
        r = $urandom;
        b = r[$bits(beat_t)-1:0];
      end
      s_axis_tdata[i*DW +: DW]   = b.data;
      s_axis_tkeep[i*KW +: KW]   = b.keep;
      s_axis_tlast[i]            = b.last;
      s_axis_tid[i*IW +: IW]     = b.id;
      s_axis_tdest[i*DSW +: DSW] = b.dest;
      s_axis_tuser[i*UW +: UW]   = b.user;
      s_axis_tvalid[i]           = drv_vld[i];
    end
    m_axis_tready = rnd_sink ? ($urandom_range(3) != 0) : sink_rdy;
  endtask

  task automatic step();
    logic [S-1:0] hs;
    @(negedge clk);
    hs = s_axis_tvalid & s_axis_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < S; i++)
      if (hs[i]) begin
        sb_q[i].push_back(src_q[i].pop_front());
        drv_vld[i] = 1'b0;
      end
    drive();
  endtask

  task automatic push_beat(int src, logic [DW-1:0] d, bit last);
    beat_t       b;
    logic [31:0] r;
    r      = $urandom;
    b.data = d;
    b.keep = r[KW-1:0];
    b.last = last;
    b.id   = IW'(src);
    b.dest = r[15:8];
    b.user = r[16 +: UW];
    src_q[src].push_back(b);
  endtask

  task automatic push_rand_pkt(int src, int len);
    logic [31:0] r;
    for (int j = 0; j < len; j++) begin
      r = $urandom;
      push_beat(src, r[DW-1:0], j == len - 1);
    end
  endtask

  task automatic clear_logs();
    out_log.delete();
    pkt_order.delete();
  endtask

  task automatic flush();
    for (int i = 0; i < S; i++) begin
      src_q[i].delete();
      sb_q[i].delete();
      drv_vld[i] = 1'b0;
    end
    cur_out_src = -1;
    clear_logs();
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < S; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(int budget);
    int n = 0;
    while (n < budget && (any_pending() || m_axis_tvalid || grant_valid)) begin
      step();
      n++;
    end
    chk("drain_within_budget", 64'(n < budget), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat[7];
    int n;
    int left;
    pat = '{1, 0, 0, 1, 0, 1, 1};
    s_axis_tvalid = '0;
    m_axis_tready = 1'b1;

    // Reset state, with a source already requesting.
    rst = 1'b0;
    flush();
    push_beat(0, 8'h5a, 1'b1);
    drive();
    @(posedge clk); #1;
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_m_tdata", 64'(m_axis_tdata), 64'(0));
    chk("rst_grant_valid", 64'(grant_valid), 64'(0));
    chk("rst_grant_index", 64'(grant_index), 64'(0));
    chk("rst_s_tready", 64'(s_axis_tready), 64'(0));
    flush();
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: three-beat packet from source 1.
    push_beat(1, 8'h11, 0); push_beat(1, 8'h22, 0); push_beat(1, 8'h33, 1);
    drive();
    chk("t1_arb_cycle_gv", 64'(grant_valid), 64'(0));
    step();
    chk("t1_gv", 64'(grant_valid), 64'(1));
    chk("t1_gi", 64'(grant_index), 64'(1));
    drain(50);
    chk("t1_count", 64'(out_log.size()), 64'(3));
    if (out_log.size() == 3) begin
      chk("t1_b0", 64'({out_log[0].data, out_log[0].last, out_log[0].id}), 64'({8'h11, 1'b0, 8'd1}));
      chk("t1_b1", 64'({out_log[1].data, out_log[1].last, out_log[1].id}), 64'({8'h22, 1'b0, 8'd1}));
      chk("t1_b2", 64'({out_log[2].data, out_log[2].last, out_log[2].id}), 64'({8'h33, 1'b1, 8'd1}));
    end
    chk("t1_gv_after", 64'(grant_valid), 64'(0));

    // 2: all sources with back-to-back 2-beat packets.
    do_reset();
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < S; i++) push_rand_pkt(i, 2);
    drive();
    drain(200);
    chk("t2_pkts", 64'(pkt_order.size()), 64'(8));
    for (int j = 0; j < pkt_order.size() && j < 8; j++)
      chk("t2_order", 64'(pkt_order[j]), 64'(j % 4));

    // 3: sink backpressure pattern.
    do_reset();
    push_beat(0, 8'ha0, 0); push_beat(0, 8'ha1, 0); push_beat(0, 8'ha2, 0); push_beat(0, 8'ha3, 1);
    drive();
    for (int k = 0; k < 7; k++) begin
      sink_rdy = pat[k];
      step();
    end
    sink_rdy = 1'b1;
    drain(50);
    chk("t3_count", 64'(out_log.size()), 64'(4));
    for (int j = 0; j < out_log.size() && j < 4; j++)
      chk("t3_data", 64'(out_log[j].data), 64'(8'ha0 + j));

    // 4: granted source stalls mid-packet while another requests.
    do_reset();
    push_beat(2, 8'h21, 0);
    push_rand_pkt(3, 2);
    drive();
    n = 0;
    while (src_q[2].size() > 0 && n < 20) begin step(); n++; end
    chk("t4_first_beat_taken", 64'(src_q[2].size()), 64'(0));
    repeat (5) begin
      step();
      chk("t4_hold_gi", 64'(grant_index), 64'(2));
      chk("t4_hold_gv", 64'(grant_valid), 64'(1));
    end
    push_beat(2, 8'h22, 1);
    drive();
    drain(50);
    chk("t4_pkts", 64'(pkt_order.size()), 64'(2));
    if (pkt_order.size() == 2) begin
      chk("t4_first", 64'(pkt_order[0]), 64'(2));
      chk("t4_second", 64'(pkt_order[1]), 64'(3));
    end

    // 5: asynchronous reset in the middle of a source-1 packet.
    clear_logs();
    push_rand_pkt(1, 4);
    drive();
    n = 0;
    while (src_q[1].size() > 2 && n < 20) begin step(); n++; end
    #2;
    rst = 1'b0;
    #1;
    chk("t5_m_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("t5_grant_valid", 64'(grant_valid), 64'(0));
    chk("t5_s_tready", 64'(s_axis_tready), 64'(0));
    chk("t5_m_tdata", 64'(m_axis_tdata), 64'(0));
    flush();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    push_beat(1, 8'h51, 1);
    push_beat(2, 8'h52, 1);
    drive();
    step();
    chk("t5_regrant_gv", 64'(grant_valid), 64'(1));
    chk("t5_regrant_gi", 64'(grant_index), 64'(1));
    drain(50);
    chk("t5_pkts", 64'(pkt_order.size()), 64'(2));
    if (pkt_order.size() == 2) chk("t5_order", 64'({pkt_order[0][3:0], pkt_order[1][3:0]}), 64'(8'h12));

    // 6: lone requester 3 is regranted after wrap.
    clear_logs();
    push_rand_pkt(3, 2);
    drive();
    drain(50);
    chk("t6_first_gi", 64'(grant_index), 64'(3));
    push_rand_pkt(3, 1);
    drive();
    step();
    chk("t6_regrant_gv", 64'(grant_valid), 64'(1));
    chk("t6_regrant_gi", 64'(grant_index), 64'(3));
    drain(50);

    // Random traffic with random source gaps and sink backpressure.
    clear_logs();
    rnd_mode = 1'b1;
    rnd_sink = 1'b1;
    repeat (3000) begin
      for (int i = 0; i < S; i++)
        if (src_q[i].size() < 6 && $urandom_range(9) == 0) push_rand_pkt(i, $urandom_range(1, 4));
      step();
    end
    rnd_mode = 1'b0;
    rnd_sink = 1'b0;
    sink_rdy = 1'b1;
    drive();
    drain(1000);
    left = 0;
    for (int i = 0; i < S; i++) left += sb_q[i].size();
    chk("rand_sb_empty", 64'(left), 64'(0));
    chk("rand_pkts_seen", 64'(pkt_order.size() > 50), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_arb_mux.md
Name: axis_arb_mux

Overview:
- Arbitrated multiplexer that merges S_COUNT AXI4-Stream sources onto one AXI4-Stream sink.
- Arbitration is per packet: a grant is held until the granted source transfers a beat with tlast.
- Uses round-robin priority, so no source starves.
- Sits in front of a shared stream resource (DMA engine, MAC TX, FIFO) that several producers must share.

Parameters:
S_COUNT, 4, number of input streams (2..16)
DATA_WIDTH, 8, tdata width per stream
KEEP_WIDTH, DATA_WIDTH/8, tkeep width per stream
ID_WIDTH, 8, tid width
DEST_WIDTH, 8, tdest width
USER_WIDTH, 1, tuser width
CL_S_COUNT, $clog2(S_COUNT), width of the grant index

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low (asserted at 0)
s_axis_tdata  input  S_COUNT*DATA_WIDTH  source data; stream i occupies slice i
s_axis_tkeep  input  S_COUNT*KEEP_WIDTH  source byte enables
s_axis_tvalid  input  S_COUNT  per-source valid
s_axis_tready  output  S_COUNT  per-source ready
s_axis_tlast  input  S_COUNT  per-source end of packet
s_axis_tid  input  S_COUNT*ID_WIDTH  source ID
s_axis_tdest  input  S_COUNT*DEST_WIDTH  source destination
s_axis_tuser  input  S_COUNT*USER_WIDTH  source user sideband
m_axis_tdata  output  DATA_WIDTH  merged data (registered)
m_axis_tkeep  output  KEEP_WIDTH  merged keep (registered)
m_axis_tvalid  output  1  merged valid (registered)
m_axis_tready  input  1  sink ready
m_axis_tlast  output  1  merged last (registered)
m_axis_tid  output  ID_WIDTH  merged ID (registered)
m_axis_tdest  output  DEST_WIDTH  merged dest (registered)
m_axis_tuser  output  USER_WIDTH  merged user (registered)
grant_valid  output  1  a source currently holds the grant
grant_index  output  CL_S_COUNT  index of the current or most recent grantee

Behaviour:
Reset (rst=0, asynchronous):
- m_axis_tvalid=0; all m_axis data/sideband outputs=0.
- grant_valid=0, grant_index=0.
- s_axis_tready=0 on every source.
- Round-robin pointer last_grant = S_COUNT-1, so source 0 wins first.

States:
- IDLE (grant_valid=0).
- GRANTED (grant_valid=1, grant_index=g).

IDLE:
- If any s_axis_tvalid is set, choose the first asserted index scanning last_grant+1, last_grant+2, … modulo S_COUNT.
- On the next edge: grant_valid<=1, grant_index<=choice, last_grant<=choice.
- Sources with tvalid=0 are never granted.
- No beat transfers in the arbitration cycle.

GRANTED:
- Only s_axis_tready[g] may be asserted.
- s_axis_tready[g] = !m_axis_tvalid || m_axis_tready (combinational path from m_axis_tready).
- Output register: on an input transfer of source g, capture all fields of slice g and set m_axis_tvalid=1.
- If m_axis_tvalid && m_axis_tready and there is no input transfer, clear m_axis_tvalid.
- A simultaneous output drain and input transfer gives full throughput: one beat per cycle.
- Latency: a beat accepted at edge N is presented on m_axis from edge N onward, i.e. valid in cycle N+1.
- Transfer of a beat with s_axis_tlast[g]=1 returns to IDLE on the same edge. grant_index keeps its value; grant_valid<=0.

Inter-packet gap:
- One arbitration cycle: s_axis_tready is 0 for all sources in that cycle.
- Output backpressure is unaffected; the held output beat still drains.

AXI-Stream rules:
- m_axis outputs stay stable while m_axis_tvalid=1 and m_axis_tready=0.
- Dropping tvalid on the granted source mid-packet does not release the grant.
- Changes on non-granted sources have no effect during GRANTED.

Wrap-around:
- The scan wraps from S_COUNT-1 to 0.
- A source that just finished has the lowest priority for the next arbitration.

Reset mid-packet:
- The partial packet is abandoned and the output register cleared.
- Sources must restart the packet after reset.

Tie-free:
- The grant is decided only in IDLE. Requests arriving during GRANTED wait.

Test Plan:
1. Reset, then source 1 sends a 3-beat packet 0x11,0x22,0x33 (tid=1, tlast on beat 3), sink always ready -> m_axis emits exactly those 3 beats with tid=1 and tlast on the third. Grant goes to index 1 one cycle after tvalid. grant_valid drops after 0x33 is accepted.
2. All 4 sources hold 2-beat packets continuously -> output packet order by source is 0,1,2,3,0,1… Each packet is contiguous, with a one-cycle s_axis_tready=0 gap between packets.
3. Source 0 sends 4 beats while m_axis_tready toggles 1,0,0,1,0,1,1 -> no beat is lost or duplicated, and m_axis fields stay stable while stalled.
4. Source 2 sends beat 1, deasserts tvalid for 5 cycles, then sends the final beat; source 3 requests throughout -> source 3 receives no grant until source 2's tlast transfers, then is granted next.
5. Assert rst=0 asynchronously mid-packet on source 1 -> m_axis_tvalid, grant_valid and all s_axis_tready drop immediately. After release, a new request from source 1 is granted first (last_grant back to S_COUNT-1).
6. Only source 3 requests after a grant to source 3 (wrap case) -> it is regranted, because the scan wraps 0,1,2,3 and finds no other requester.
